// File: rtl/m8b_32b_pack_pkg.sv
// Shared constants and helpers for the narrow-to-wide packer.
// Optional parity output is enabled by defining PACK_PARITY_EN.
package pack_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_RATIO = 4;
    localparam int OUT_W     = DEF_IN_W * DEF_RATIO;

    // Beat-index width; never narrower than one bit.
    function automatic int idx_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Lane that the beat at position idx lands in.
    function automatic int lane_of(input int idx, input bit lsb_first, input int ratio);
        return lsb_first ? idx : (ratio - 1 - idx);
    endfunction

endpackage

// File: rtl/m8b_32b_pack_if.sv
// Bus bundle for the packer: narrow input side and wide output side.
// Defining PACK_PARITY_EN adds the per-lane parity_out signal.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds data stable while valid && !ready, and valid never waits on ready.
interface m8b_32b_pack_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    logic [IN_W-1:0]       data_in;
    logic                  valid_in;
    logic                  in_ready;
    logic                  flush;
    logic [IN_W*RATIO-1:0] data_out;
    logic                  valid_out;
    logic [RATIO-1:0]      lane_en;
    logic                  out_ready;
`ifdef PACK_PARITY_EN
    logic [RATIO-1:0]      parity_out;
`endif

    modport master (
        output data_in, valid_in, flush, out_ready,
        input  in_ready, data_out, valid_out, lane_en
`ifdef PACK_PARITY_EN
        , input parity_out
`endif
    );

    modport slave (
        input  data_in, valid_in, flush, out_ready,
        output in_ready, data_out, valid_out, lane_en
`ifdef PACK_PARITY_EN
        , output parity_out
`endif
    );

endinterface

// File: rtl/m8b_32b_pack_out_reg.sv
// One-deep registered output stage of the packer; also reports whether it can load.
// With PACK_PARITY_EN defined it registers per-lane even parity alongside the data.
module pack_out_reg #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic                  clk_4f,
    input  logic                  reset_L,
    input  logic                  load,
    input  logic [IN_W*RATIO-1:0] load_data,
    input  logic [RATIO-1:0]      load_lane_en,
    input  logic                  out_ready,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic                  valid_out,
    output logic [RATIO-1:0]      lane_en,
`ifdef PACK_PARITY_EN
    output logic [RATIO-1:0]      parity_out,
`endif
    output logic                  load_ok
);

    logic [IN_W*RATIO-1:0] data_q, data_d;
    logic [RATIO-1:0]      lane_en_q, lane_en_d;
    logic                  valid_q, valid_d;

    assign load_ok = !valid_q || out_ready;

    always_comb begin
        data_d    = data_q;
        lane_en_d = lane_en_q;
        valid_d   = valid_q;
        if (load) begin
            data_d    = load_data;
            lane_en_d = load_lane_en;
            valid_d   = 1'b1;
        end else if (out_ready) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            data_q    <= '0;
            lane_en_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            lane_en_q <= lane_en_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign lane_en   = lane_en_q;
    assign valid_out = valid_q;

`ifdef PACK_PARITY_EN
    logic [RATIO-1:0] parity_q, parity_d, parity_next;

    // Unfilled lanes are zero in load_data, so their parity is 0 automatically.
    always_comb begin
        parity_next = '0;
        for (int l = 0; l < RATIO; l++) begin
            parity_next[l] = ^load_data[l*IN_W +: IN_W];
        end
        parity_d = load ? parity_next : parity_q;
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) parity_q <= '0;
        else          parity_q <= parity_d;
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: rtl/m8b_32b_pack.sv
// Packs RATIO narrow beats into one wide word with backpressure, flush and lane order.
// Defining PACK_PARITY_EN adds the registered per-lane parity_out output.
module m8b_32b_pack #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic          clk_4f,
    input  logic          reset_L,
    m8b_32b_pack_if.slave pif
);
    import pack_pkg::*;

    localparam int IDX_W = idx_w(RATIO);
    localparam int W_OUT = IN_W * RATIO;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W_OUT-1:0] buf_q, buf_d, buf_next;
    logic [RATIO-1:0] fill_q, fill_d, fill_next;
    logic [IDX_W-1:0] lane;
    logic             load_ok, accept, last_beat, do_flush, load;

    assign lane        = IDX_W'(lane_of(int'(idx_q), LSB_FIRST, RATIO));
    assign last_beat   = (idx_q == LAST_IDX);
    // Only the completing beat needs room in the output register.
    assign pif.in_ready = !(last_beat && !load_ok);
    assign accept      = pif.valid_in && pif.in_ready;
    assign do_flush    = pif.flush && load_ok && ((idx_q != '0) || accept);
    assign load        = (accept && last_beat) || do_flush;

    // Buffer contents including this cycle's beat; this is what a load captures.
    always_comb begin
        buf_next  = buf_q;
        fill_next = fill_q;
        if (accept) begin
            buf_next[lane*IN_W +: IN_W] = pif.data_in;
            fill_next[lane]             = 1'b1;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        buf_d  = buf_q;
        fill_d = fill_q;
        if (load) begin
            idx_d  = '0;
            buf_d  = '0;
            fill_d = '0;
        end else if (accept) begin
            idx_d  = idx_q + IDX_W'(1);
            buf_d  = buf_next;
            fill_d = fill_next;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            idx_q  <= '0;
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            idx_q  <= idx_d;
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    pack_out_reg #(
        .IN_W  (IN_W),
        .RATIO (RATIO)
    ) u_out_reg (
        .clk_4f       (clk_4f),
        .reset_L      (reset_L),
        .load         (load),
        .load_data    (buf_next),
        .load_lane_en (fill_next),
        .out_ready    (pif.out_ready),
        .data_out     (pif.data_out),
        .valid_out    (pif.valid_out),
        .lane_en      (pif.lane_en),
`ifdef PACK_PARITY_EN
        .parity_out   (pif.parity_out),
`endif
        .load_ok      (load_ok)
    );

endmodule

// File: tb/tb_m8b_32b_pack.sv
// Bench for m8b_32b_pack: an LSB-first and an MSB-first instance driven in lockstep.
module tb_m8b_32b_pack;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
  localparam int EW    = OUT_W + RATIO;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b0;
  int   cyc     = 0;

  always #5 clk_4f = ~clk_4f;
  always @(posedge clk_4f) cyc <= cyc + 1;

  m8b_32b_pack_if #(.IN_W(IN_W), .RATIO(RATIO)) lsb_if ();
  m8b_32b_pack_if #(.IN_W(IN_W), .RATIO(RATIO)) msb_if ();

  assign msb_if.data_in   = lsb_if.data_in;
  assign msb_if.valid_in  = lsb_if.valid_in;
  assign msb_if.flush     = lsb_if.flush;
  assign msb_if.out_ready = lsb_if.out_ready;

  m8b_32b_pack #(.IN_W(IN_W), .RATIO(RATIO), .LSB_FIRST(1'b1)) dut_lsb (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .pif     (lsb_if.slave)
  );

  m8b_32b_pack #(.IN_W(IN_W), .RATIO(RATIO), .LSB_FIRST(1'b0)) dut_msb (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .pif     (msb_if.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_msb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [RATIO-1:0] par_of(input logic [OUT_W-1:0] d);
    logic [RATIO-1:0] p;
    for (int l = 0; l < RATIO; l++) p[l] = ^d[l*IN_W +: IN_W];
    return p;
  endfunction

  task automatic push_exp(input logic [31:0] dl, input logic [3:0] ll,
                          input logic [31:0] dm, input logic [3:0] lm);
    exp_q.push_back({ll, dl});
    exp_msb_q.push_back({lm, dm});
  endtask

  // Scoreboard: a word is taken on the edge following this sample point.
  always @(negedge clk_4f) begin
    logic [EW-1:0] e;
    #2;
    if (reset_L && lsb_if.valid_out && lsb_if.out_ready) begin
      if (exp_q.size() == 0) check("lsb_unexpected_word", lsb_if.data_out, 32'hx);
      else begin
        e = exp_q.pop_front();
        check("lsb_data", lsb_if.data_out, e[OUT_W-1:0]);
        check("lsb_lane_en", 32'(lsb_if.lane_en), 32'(e[EW-1:OUT_W]));
`ifdef PACK_PARITY_EN
        check("lsb_parity", 32'(lsb_if.parity_out), 32'(par_of(e[OUT_W-1:0])));
`endif
      end
    end
    if (reset_L && msb_if.valid_out && msb_if.out_ready) begin
      if (exp_msb_q.size() == 0) check("msb_unexpected_word", msb_if.data_out, 32'hx);
      else begin
        e = exp_msb_q.pop_front();
        check("msb_data", msb_if.data_out, e[OUT_W-1:0]);
        check("msb_lane_en", 32'(msb_if.lane_en), 32'(e[EW-1:OUT_W]));
`ifdef PACK_PARITY_EN
        check("msb_parity", 32'(msb_if.parity_out), 32'(par_of(e[OUT_W-1:0])));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [7:0] d);
    int   n = 0;
    logic acc;
    lsb_if.data_in  = d;
    lsb_if.valid_in = 1'b1;
    do begin
      #1;
      acc = lsb_if.in_ready;
      @(negedge clk_4f);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("beat_accept_timeout", 32'(acc), 32'd1);
    lsb_if.valid_in = 1'b0;
  endtask

  task automatic flush_pulse();
    lsb_if.flush = 1'b1;
    @(negedge clk_4f);
    lsb_if.flush = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] dl, input logic [3:0] ll,
                           input logic [31:0] dm, input logic [3:0] lm, input logic v);
    check({name, "_lsb_valid"}, 32'(lsb_if.valid_out), 32'(v));
    check({name, "_lsb_data"}, lsb_if.data_out, dl);
    check({name, "_lsb_lane"}, 32'(lsb_if.lane_en), 32'(ll));
    check({name, "_msb_data"}, msb_if.data_out, dm);
    check({name, "_msb_lane"}, 32'(msb_if.lane_en), 32'(lm));
  endtask

  typedef struct {
    int          n;
    logic [31:0] beats;
    logic        fl;
    logic [31:0] dl;
    logic [3:0]  ll;
    logic [31:0] dm;
    logic [3:0]  lm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0;

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111, 32'h11223344, 4'b1111};
    vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'b0011, 32'hAABB0000, 4'b1100};
    vecs[2] = '{1, 32'h00000011, 1'b1, 32'h00000011, 4'b0001, 32'h11000000, 4'b1000};
    vecs[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'b0111, 32'h01020300, 4'b1110};
    vecs[4] = '{1, 32'h00000001, 1'b1, 32'h00000001, 4'b0001, 32'h01000000, 4'b1000};
    vecs[5] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'b1111, 32'hDEADBEEF, 4'b1111};

    lsb_if.data_in   = '0;
    lsb_if.valid_in  = 1'b0;
    lsb_if.flush     = 1'b0;
    lsb_if.out_ready = 1'b1;
    repeat (3) @(negedge clk_4f);
    check_out("reset", 32'h0, 4'h0, 32'h0, 4'h0, 1'b0);
    check("reset_in_ready", 32'(lsb_if.in_ready), 32'd1);
`ifdef PACK_PARITY_EN
    check("reset_parity", 32'(lsb_if.parity_out), 32'd0);
`endif
    reset_L = 1'b1;
    @(negedge clk_4f);

    // Table-driven words and partial flushes, back-to-back.
    for (int v = 0; v < 6; v++) begin
      push_exp(vecs[v].dl, vecs[v].ll, vecs[v].dm, vecs[v].lm);
      for (int b = 0; b < vecs[v].n; b++) send_beat(vecs[v].beats[8*b +: 8]);
      if (vecs[v].fl) flush_pulse();
    end
    repeat (2) @(negedge clk_4f);

    // Eight beats back-to-back: one beat per cycle, valid_out one cycle per word.
    push_exp(32'h44332211, 4'hF, 32'h11223344, 4'hF);
    push_exp(32'h88776655, 4'hF, 32'h55667788, 4'hF);
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'((i + 1) * 8'h11);
      send_beat(b);
      check("b2b_valid_out", 32'(lsb_if.valid_out), (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    check("b2b_cycles", 32'(cyc - c0), 32'd8);
    @(negedge clk_4f);

    // Spaced beats: no word before the fourth beat.
    push_exp(32'h44332211, 4'hF, 32'h11223344, 4'hF);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'((i + 1) * 8'h11);
      send_beat(b);
      if (i < 3) begin
        repeat (2) begin
          check("spaced_no_valid", 32'(lsb_if.valid_out), 32'd0);
          @(negedge clk_4f);
        end
      end
    end
    check_out("spaced_word", 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b1);
    @(negedge clk_4f);

    // Backpressure: fill 3 beats behind a held word, 4th waits for out_ready.
    push_exp(32'h44332211, 4'hF, 32'h11223344, 4'hF);
    push_exp(32'hA4A3A2A1, 4'hF, 32'hA1A2A3A4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'((i + 1) * 8'h11);
      send_beat(b);
    end
    lsb_if.out_ready = 1'b0;
    send_beat(8'hA1);
    send_beat(8'hA2);
    send_beat(8'hA3);
    lsb_if.data_in  = 8'hA4;
    lsb_if.valid_in = 1'b1;
    #1;
    check("bp_in_ready_low", 32'(lsb_if.in_ready), 32'd0);
    check_out("bp_hold", 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b1);
    @(negedge clk_4f);
    #1;
    check("bp_in_ready_low2", 32'(lsb_if.in_ready), 32'd0);
    check_out("bp_hold2", 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b1);
    lsb_if.out_ready = 1'b1;
    #0;
    check("bp_in_ready_release", 32'(lsb_if.in_ready), 32'd1);
    @(negedge clk_4f);
    lsb_if.valid_in = 1'b0;
    check_out("bp_next_word", 32'hA4A3A2A1, 4'hF, 32'hA1A2A3A4, 4'hF, 1'b1);
    @(negedge clk_4f);

    // Flush with an empty word does nothing.
    flush_pulse();
    check("flush_empty_no_valid", 32'(lsb_if.valid_out), 32'd0);
    @(negedge clk_4f);

    // Flush while output is stalled waits until the word drains.
    push_exp(32'hC4C3C2C1, 4'hF, 32'hC1C2C3C4, 4'hF);
    push_exp(32'h00000077, 4'b0001, 32'h77000000, 4'b1000);
    send_beat(8'hC1);
    send_beat(8'hC2);
    send_beat(8'hC3);
    send_beat(8'hC4);
    lsb_if.out_ready = 1'b0;
    send_beat(8'h77);
    lsb_if.flush = 1'b1;
    @(negedge clk_4f);
    check_out("flush_stalled", 32'hC4C3C2C1, 4'hF, 32'hC1C2C3C4, 4'hF, 1'b1);
    @(negedge clk_4f);
    check_out("flush_stalled2", 32'hC4C3C2C1, 4'hF, 32'hC1C2C3C4, 4'hF, 1'b1);
    lsb_if.out_ready = 1'b1;
    @(negedge clk_4f);
    lsb_if.flush = 1'b0;
    check_out("flush_released", 32'h00000077, 4'b0001, 32'h77000000, 4'b1000, 1'b1);
    @(negedge clk_4f);

    // Reset mid-word discards the partial beats.
    send_beat(8'h55);
    send_beat(8'h66);
    reset_L = 1'b0;
    @(negedge clk_4f);
    check_out("mid_reset", 32'h0, 4'h0, 32'h0, 4'h0, 1'b0);
    check("mid_reset_msb_valid", 32'(msb_if.valid_out), 32'd0);
    reset_L = 1'b1;
    push_exp(32'h04030201, 4'hF, 32'h01020304, 4'hF);
    send_beat(8'h01);
    send_beat(8'h02);
    send_beat(8'h03);
    send_beat(8'h04);
    check_out("post_reset_word", 32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b1);

    repeat (4) @(negedge clk_4f);
    check("lsb_queue_drained", 32'(exp_q.size()), 32'd0);
    check("msb_queue_drained", 32'(exp_msb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/m8b_32b_pack.md
Name: m8b_32b_pack

Overview:
- Parametrised successor of the fixed 8-bit to 32-bit packer.
- Collects RATIO narrow beats of IN_W bits into one wide word of IN_W*RATIO bits, on a single clock.
- Adds output backpressure (ready/valid), partial-word flush with lane enables, and selectable lane order.
- Sits on the narrow-to-wide side of the datapath, feeding wide consumers such as FIFOs and demuxes.

Parameters:
- IN_W, 8, narrow beat width in bits.
- RATIO, 4, beats per wide word; must be ≥2.
- LSB_FIRST, 1, 1: first beat lands in lane 0 (bits IN_W-1:0); 0: first beat lands in lane RATIO-1.

Ports:
- clk_4f  in  1  single clock, rising edge; narrow-beat rate.
- reset_L  in  1  synchronous, active-low reset.
- data_in  in  IN_W  narrow beat.
- valid_in  in  1  beat present.
- in_ready  out  1  beat accepted when valid_in&&in_ready (combinational).
- flush  in  1  level request: emit the partial word.
- data_out  out  IN_W*RATIO  packed word (registered).
- valid_out  out  1  word present (registered).
- lane_en  out  RATIO  per-lane filled mask, registered with data_out.
- out_ready  in  1  consumer takes the word when valid_out&&out_ready.

Behaviour:
Reset (reset_L=0 at a clk_4f edge):
- data_out=0, valid_out=0, lane_en=0.
- Beat index idx=0, assembly buffer=0.
- Any partial word is discarded.
- Reset has priority over every other event.

Internal state:
- Assembly buffer plus idx (0..RATIO-1).
- Output register is one word deep.
- load_ok = !valid_out || out_ready (the output register can load this cycle).

Accept:
- in_ready = !(idx==RATIO-1 && !load_ok).
- An accepted beat writes lane L, where L=idx if LSB_FIRST=1, else L=RATIO-1-idx. Then idx++.

Complete:
- The beat accepted at idx==RATIO-1 loads the output register at the same edge.
- Next cycle: data_out = full word, valid_out=1, lane_en=all ones.
- idx wraps to 0 and the buffer clears.
- Latency: one cycle from the last accepted beat to valid_out.

Hold:
- valid_out && !out_ready: data_out and lane_en are held stable, and valid_out stays high.
- Filling of the next word continues up to RATIO-1 beats.

Drain:
- valid_out && out_ready with no load: valid_out falls next cycle.
- valid_out && out_ready with a simultaneous load: the new word replaces the old one back-to-back. No bubble; valid_out stays 1.

Flush:
- Honoured only when load_ok=1 and the word is non-empty. Non-empty means idx>0, or a beat is accepted in the same cycle.
- The beat accepted in the same cycle is included in the flushed word.
- The output register loads the partial word: unfilled lanes are 0, and lane_en marks the filled lanes.
- idx returns to 0.
- flush with an empty word: no output and no state change.
- flush while load_ok=0: no effect; the source must hold flush high.
- flush on a completing beat: treated as a normal full word.

Throughput:
- Sustained one beat per cycle whenever out_ready stays high.

valid_out:
- Never depends combinationally on valid_in.

Optional Feature:
- Macro PACK_PARITY_EN.
- Defined: adds output parity_out [RATIO], registered with data_out. Bit L is the even parity (XOR) of lane L; unfilled lanes give 0. Reset value is 0. It is held with data_out under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pack_pkg holds:
  - function clog2-based IDX_W(RATIO);
  - localparam OUT_W = IN_W*RATIO;
  - the lane-mapping function lane_of(idx, LSB_FIRST).
- One sub-module: pack_out_reg, the one-deep output stage. It holds data_out, lane_en, valid_out and optional parity_out, and generates load_ok.
- The top level keeps the assembly buffer, idx, accept logic and flush logic.

Test Plan:
Defaults IN_W=8, RATIO=4, out_ready=1 unless noted.
1. Beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> next cycle data_out=0x44332211, lane_en=4'b1111, valid_out high for exactly 1 cycle. Eight beats back-to-back give two words on adjacent output cycles.
2. Same beats with valid_in low for 2 cycles between each beat -> one word 0x44332211, no valid_out before the 4th beat.
3. out_ready=0 after word A=0x44332211; feed 0xA1..0xA4:
   - 3 beats accepted; in_ready=0 on the 4th;
   - data_out holds A;
   - raise out_ready -> 4th beat accepted the same cycle, and data_out=0xA4A3A2A1 on the next cycle with no valid_out gap.
4. Beats 0xAA, 0xBB, then flush -> data_out=0x0000BBAA, lane_en=4'b0011. Next 4 beats pack normally. With PACK_PARITY_EN, parity_out=4'b0000 for 0xAA/0xBB; 0x01 in lane 0 gives parity bit 0 = 1.
5. Two beats 0x55, 0x66, then reset_L=0 for 1 cycle, then beats 0x01..0x04 -> all outputs 0 during reset; single word 0x04030201 with no trace of the discarded beats.
6. LSB_FIRST=0, beats 0x11..0x44 -> data_out=0x11223344. Flush after 1 beat 0x11 -> 0x11000000, lane_en=4'b1000.
